// File: rtl/bht_pkg.sv
// Shared definitions for the branch history table controller.
//   ENTRIES  - number of 2-bit counters (fixed by the 6-bit index)
//   IDX_W    - index width
//   INIT_VAL - value written into every counter by the init walk
//   CNT_W    - default width of the mispredict counter
//   state_e  - controller states
//   sat_inc / sat_dec - 2-bit saturating counter steps
package bht_pkg;

    localparam int unsigned ENTRIES  = 64;
    localparam int unsigned IDX_W    = 6;
    localparam logic [1:0]  INIT_VAL = 2'b01;
    localparam int unsigned CNT_W    = 16;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } state_e;

    function automatic logic [1:0] sat_inc(input logic [1:0] v);
        return (v == 2'b11) ? v : v + 2'b01;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] v);
        return (v == 2'b00) ? v : v - 2'b01;
    endfunction

endpackage

// File: rtl/mux_64_2_bit.sv
// 64-to-1 multiplexer of 2-bit words.
//   data_i - 64 packed 2-bit words
//   sel_i  - word select
//   data_o - selected word
module mux_64_2_bit (
    input  logic [63:0][1:0] data_i,
    input  logic [5:0]       sel_i,
    output logic [1:0]       data_o
);

    assign data_o = data_i[sel_i];

endmodule

// File: rtl/bht_ctrl.sv
// Branch history table controller: 64 two-bit saturating counters with a
// combinational lookup port, a valid/ready update port, a walking init FSM
// that clears the table after reset or flush, and a saturating mispredict
// counter.
//   clk_i, rst_ni        - clock, asynchronous active-low reset
//   flush_i              - level request to re-initialise the table
//   busy_o               - high while the init walk is running
//   lk_index_i           - lookup index
//   lk_counter_o         - counter at lk_index_i (pre-update value)
//   lk_pred_o            - predicted taken; forced low while busy
//   up_valid_i/_ready_o  - update handshake
//   up_index_i           - index of the resolved branch
//   up_taken_i           - resolved outcome
//   mispredict_count_o   - saturating count of mispredicted updates
module bht_ctrl
    import bht_pkg::*;
#(
    parameter int unsigned CNT_W = bht_pkg::CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    output logic             busy_o,
    input  logic [5:0]       lk_index_i,
    output logic [1:0]       lk_counter_o,
    output logic             lk_pred_o,
    input  logic             up_valid_i,
    input  logic [5:0]       up_index_i,
    input  logic             up_taken_i,
    output logic             up_ready_o,
    output logic [CNT_W-1:0] mispredict_count_o
);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   init_ptr_q, init_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [63:0][1:0]   bht_q;
    logic [ENTRIES-1:0] wr_en;
    logic [1:0]         wr_data;
    logic [1:0]         up_rd;
    logic               up_fire;

    mux_64_2_bit u_lk_mux (
        .data_i (bht_q),
        .sel_i  (lk_index_i),
        .data_o (lk_counter_o)
    );

    mux_64_2_bit u_up_mux (
        .data_i (bht_q),
        .sel_i  (up_index_i),
        .data_o (up_rd)
    );

    assign busy_o             = (state_q == ST_INIT);
    assign up_ready_o         = (state_q == ST_IDLE) && !flush_i;
    assign up_fire            = up_valid_i && up_ready_o;
    assign lk_pred_o          = lk_counter_o[1] && !busy_o;
    assign mispredict_count_o = cnt_q;

    // NOTE: every signal driven here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        init_ptr_d = init_ptr_q;
        cnt_d      = cnt_q;
        wr_en      = '0;
        wr_data    = INIT_VAL;

        unique case (state_q)
            ST_INIT: begin
                wr_en[init_ptr_q] = 1'b1;
                if (flush_i) begin
                    init_ptr_d = '0;
                end else begin
                    // Pointer wraps to 0 naturally on the last entry.
                    init_ptr_d = init_ptr_q + 1'b1;
                    if (init_ptr_q == IDX_W'(ENTRIES - 1)) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_IDLE: begin
                if (flush_i) begin
                    state_d    = ST_INIT;
                    init_ptr_d = '0;
                end else if (up_fire) begin
                    wr_en[up_index_i] = 1'b1;
                    wr_data = up_taken_i ? sat_inc(up_rd) : sat_dec(up_rd);
                    // Mispredict compares against the pre-update prediction bit.
                    if ((up_taken_i != up_rd[1]) && !(&cnt_q)) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: ;
        endcase

        if (flush_i) begin
            cnt_d = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its next value from the same pre-edge snapshot.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_INIT;
            init_ptr_q <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            init_ptr_q <= init_ptr_d;
            cnt_q      <= cnt_d;
        end
    end

    // NOTE: the table has no reset; the init walk gives it defined contents
    // before any lookup result is trusted.
    for (genvar e = 0; e < ENTRIES; e++) begin : g_entry
        always_ff @(posedge clk_i) begin
            if (wr_en[e]) begin
                bht_q[e] <= wr_data;
            end
        end
    end

endmodule

// File: tb/tb_bht_ctrl.sv
module tb_bht_ctrl;
    localparam int unsigned TB_CNT_W = 4;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                flush;
    logic                busy;
    logic [5:0]          lk_index;
    logic [1:0]          lk_counter;
    logic                lk_pred;
    logic                up_valid;
    logic [5:0]          up_index;
    logic                up_taken;
    logic                up_ready;
    logic [TB_CNT_W-1:0] mcount;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: plain integer counters and a clamped miss count.
    int mdl[64];
    int mcnt;

    bht_ctrl #(.CNT_W(TB_CNT_W)) dut (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .flush_i            (flush),
        .busy_o             (busy),
        .lk_index_i         (lk_index),
        .lk_counter_o       (lk_counter),
        .lk_pred_o          (lk_pred),
        .up_valid_i         (up_valid),
        .up_index_i         (up_index),
        .up_taken_i         (up_taken),
        .up_ready_o         (up_ready),
        .mispredict_count_o (mcount)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) mdl[i] = 1;
        mcnt = 0;
    endtask

    task automatic model_update(input int idx, input bit taken);
        int old;
        old = mdl[idx];
        if (int'(taken) != (old / 2)) mcnt = (mcnt < 15) ? mcnt + 1 : 15;
        mdl[idx] = taken ? ((old < 3) ? old + 1 : 3) : ((old > 0) ? old - 1 : 0);
    endtask

    task automatic do_update(input logic [5:0] idx, input logic taken);
        up_valid = 1'b1;
        up_index = idx;
        up_taken = taken;
        #1;
        check("up_ready_before_update", up_ready, 1);
        tick();
        up_valid = 1'b0;
        model_update(idx, taken);
    endtask

    // Counts edges of an init walk already started by the previous edge.
    task automatic expect_walk_rest(input string name, input int remaining);
        for (int k = 0; k < remaining - 1; k++) begin
            check({name, "_busy_mid"}, busy, 1);
            tick();
        end
        check({name, "_busy_last"}, busy, 1);
        tick();
        check({name, "_busy_done"}, busy, 0);
        check({name, "_ready_done"}, up_ready, 1);
    endtask

    typedef struct {
        logic [5:0] idx;
        logic       taken;
        logic [1:0] exp_ctr;
        logic       exp_pred;
        logic [3:0] exp_cnt;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{6'd5,  1'b1, 2'b10, 1'b1, 4'd1};
        vecs[1] = '{6'd5,  1'b1, 2'b11, 1'b1, 4'd1};
        vecs[2] = '{6'd5,  1'b1, 2'b11, 1'b1, 4'd1};
        vecs[3] = '{6'd63, 1'b0, 2'b00, 1'b0, 4'd1};
        vecs[4] = '{6'd63, 1'b0, 2'b00, 1'b0, 4'd1};
        vecs[5] = '{6'd63, 1'b1, 2'b01, 1'b0, 4'd2};

        rst_n = 1'b0; flush = 1'b0; lk_index = '0;
        up_valid = 1'b0; up_index = '0; up_taken = 1'b0;
        #12;
        check("rst_busy", busy, 1);
        check("rst_ready", up_ready, 0);
        check("rst_pred", lk_pred, 0);
        check("rst_count", mcount, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        expect_walk_rest("init", 63);

        model_reset();
        for (int i = 0; i < 64; i++) begin
            lk_index = 6'(i);
            #1;
            check("init_lk_counter", lk_counter, 1);
            check("init_lk_pred", lk_pred, 0);
        end

        for (int v = 0; v < 6; v++) begin
            do_update(vecs[v].idx, vecs[v].taken);
            lk_index = vecs[v].idx;
            #1;
            check("vec_counter", lk_counter, vecs[v].exp_ctr);
            check("vec_pred", lk_pred, vecs[v].exp_pred);
            check("vec_count", mcount, vecs[v].exp_cnt);
        end

        // Same-cycle lookup and update: pre-update value, then new value.
        lk_index = 6'd7;
        up_valid = 1'b1; up_index = 6'd7; up_taken = 1'b1;
        #1;
        check("bypass_pre", lk_counter, 1);
        tick();
        up_valid = 1'b0;
        model_update(7, 1'b1);
        check("bypass_post", lk_counter, 2);

        // Randomised traffic against the model.
        for (int it = 0; it < 400; it++) begin
            lk_index = 6'($urandom_range(63));
            up_valid = 1'($urandom_range(1));
            up_index = ($urandom_range(3) == 0) ? lk_index : 6'($urandom_range(63));
            up_taken = 1'($urandom_range(1));
            #1;
            check("rnd_lk_counter", lk_counter, mdl[lk_index]);
            check("rnd_lk_pred", lk_pred, mdl[lk_index] / 2);
            check("rnd_ready", up_ready, 1);
            tick();
            if (up_valid) model_update(up_index, up_taken);
            check("rnd_count", mcount, mcnt);
        end
        up_valid = 1'b0;

        // Flush in IDLE with a simultaneous update: update is dropped.
        flush = 1'b1;
        up_valid = 1'b1; up_index = 6'd10; up_taken = 1'b0;
        #1;
        check("flush_ready_low", up_ready, 0);
        tick();
        flush = 1'b0; up_valid = 1'b0;
        model_reset();
        check("flush_count_clr", mcount, 0);
        expect_walk_rest("flush", 64);
        lk_index = 6'd10;
        #1;
        check("flush_idx10", lk_counter, 1);

        // Flush during INIT restarts the walk from entry 0.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        expect_walk_rest("reflush", 64);

        // Saturation: alternating outcomes on one entry always mispredict.
        for (int k = 0; k < 20; k++) begin
            do_update(6'd20, (k % 2 == 0) ? 1'b1 : 1'b0);
            check("sat_count_step", mcount, mcnt);
        end
        check("sat_count_final", mcount, 4'hF);

        // Asynchronous reset mid-operation.
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_busy", busy, 1);
        check("async_rst_ready", up_ready, 0);
        check("async_rst_count", mcount, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        expect_walk_rest("reinit", 63);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
